// File: rtl/register_bank_init.sv
// Bank of DEPTH x WIDTH registers with per-entry init values, byte-enabled one-hot writes and valid bits.
// Two registered read ports (1-cycle, write-first bypass); multi-cycle flush sequencer; no backpressure, busy flags flush.
module register_bank_init #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int NBYTE = WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     regWrite,
  input  logic [DEPTH-1:0]         decOut,
  input  logic [NBYTE-1:0]         byteEn,
  input  logic [WIDTH-1:0]         writeData,
  input  logic [DEPTH*WIDTH-1:0]   initialData,
  input  logic [AW-1:0]            rdAddrA,
  input  logic [AW-1:0]            rdAddrB,
  output logic [WIDTH-1:0]         rdDataA,
  output logic [WIDTH-1:0]         rdDataB,
  output logic                     rdValidA,
  output logic                     rdValidB,
  output logic                     writeErr,
  input  logic                     flushReq,
  output logic                     busy,
  output logic                     flushDone
);

  typedef enum logic {IDLE, FLUSH} state_e;

  localparam int            NADDR = 1 << AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        data_q [DEPTH];
  logic [WIDTH-1:0]        data_d [DEPTH];
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [WIDTH-1:0]        rd_a_dat_q, rd_a_dat_d, rd_b_dat_q, rd_b_dat_d;
  logic                    rd_a_vld_q, rd_a_vld_d, rd_b_vld_q, rd_b_vld_d;
  logic                    werr_q, werr_d;
  logic                    done_q, done_d;

  logic                    sel_onehot;
  logic [DEPTH-1:0]        dec_minus1;
  logic [WIDTH-1:0]        ext_dat [NADDR];
  logic [NADDR-1:0]        ext_vld;

  assign dec_minus1 = decOut - DEPTH'(1);
  assign sel_onehot = (decOut != '0) && ((decOut & dec_minus1) == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    werr_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (regWrite) begin
          if (sel_onehot) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (decOut[i]) begin
                for (int b = 0; b < NBYTE; b++) begin
                  if (byteEn[b]) data_d[i][8*b +: 8] = writeData[8*b +: 8];
                end
                valid_d[i] = 1'b1;
              end
            end
          end else begin
            werr_d = 1'b1;
          end
        end
        if (flushReq) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        // Writes are dropped here; only the entry under the counter changes.
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_q == AW'(i)) begin
            data_d[i]  = initialData[i*WIDTH +: WIDTH];
            valid_d[i] = 1'b0;
          end
        end
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Reads look at next-state contents, giving write-first / flush-first bypass.
    for (int i = 0; i < NADDR; i++) begin
      ext_dat[i] = '0;
      ext_vld[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      ext_dat[i] = data_d[i];
      ext_vld[i] = valid_d[i];
    end
    rd_a_dat_d = ext_dat[rdAddrA];
    rd_a_vld_d = ext_vld[rdAddrA];
    rd_b_dat_d = ext_dat[rdAddrB];
    rd_b_vld_d = ext_vld[rdAddrB];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      rd_a_dat_q <= '0;
      rd_b_dat_q <= '0;
      rd_a_vld_q <= 1'b0;
      rd_b_vld_q <= 1'b0;
      werr_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= initialData[i*WIDTH +: WIDTH];
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      rd_a_dat_q <= rd_a_dat_d;
      rd_b_dat_q <= rd_b_dat_d;
      rd_a_vld_q <= rd_a_vld_d;
      rd_b_vld_q <= rd_b_vld_d;
      werr_q     <= werr_d;
      done_q     <= done_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

  assign rdDataA   = rd_a_dat_q;
  assign rdDataB   = rd_b_dat_q;
  assign rdValidA  = rd_a_vld_q;
  assign rdValidB  = rd_b_vld_q;
  assign writeErr  = werr_q;
  assign busy      = (state_q == FLUSH);
  assign flushDone = done_q;

endmodule

// File: tb/tb_register_bank_init.sv
// Scoreboard bench for register_bank_init: a behavioural model queues expected outputs per cycle.
module tb_register_bank_init;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int NB = W / 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             regWrite;
  logic [D-1:0]     decOut;
  logic [NB-1:0]    byteEn;
  logic [W-1:0]     writeData;
  logic [D*W-1:0]   initialData;
  logic [AW-1:0]    rdAddrA, rdAddrB;
  logic [W-1:0]     rdDataA, rdDataB;
  logic             rdValidA, rdValidB, writeErr, flushReq, busy, flushDone;

  register_bank_init #(.WIDTH(W), .DEPTH(D), .AW(AW), .NBYTE(NB)) dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .decOut(decOut), .byteEn(byteEn),
    .writeData(writeData), .initialData(initialData), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
    .rdDataA(rdDataA), .rdDataB(rdDataB), .rdValidA(rdValidA), .rdValidB(rdValidB),
    .writeErr(writeErr), .flushReq(flushReq), .busy(busy), .flushDone(flushDone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] da;
    logic [W-1:0] db;
    logic         va;
    logic         vb;
    logic         err;
    logic         bsy;
    logic         done;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_data [D];
  logic [D-1:0] m_valid;
  logic         m_busy;
  int           m_cnt;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] init_of(input int i);
    return initialData[i*W +: W];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_data[i] = init_of(i);
    m_valid = '0;
    m_busy  = 1'b0;
    m_cnt   = 0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    regWrite  = 1'b0;
    decOut    = '0;
    byteEn    = '0;
    writeData = '0;
    flushReq  = 1'b0;
  endtask

  // One clock: predict from current inputs, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    exp_t o;
    e = '0;
    if (!m_busy && regWrite) begin
      if ($countones(decOut) == 1) begin
        for (int i = 0; i < D; i++) begin
          if (decOut[i]) begin
            for (int b = 0; b < NB; b++)
              if (byteEn[b]) m_data[i][8*b +: 8] = writeData[8*b +: 8];
            m_valid[i] = 1'b1;
          end
        end
      end else begin
        e.err = 1'b1;
      end
    end else if (m_busy) begin
      m_data[m_cnt]  = init_of(m_cnt);
      m_valid[m_cnt] = 1'b0;
    end
    e.da = m_data[rdAddrA];
    e.db = m_data[rdAddrB];
    e.va = m_valid[rdAddrA];
    e.vb = m_valid[rdAddrB];
    if (!m_busy) begin
      if (flushReq) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (m_cnt == D - 1) begin
      m_busy = 1'b0;
      e.done = 1'b1;
    end else begin
      m_cnt++;
    end
    e.bsy = m_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      o = sb.pop_front();
      chk("rdDataA", rdDataA, o.da);
      chk("rdDataB", rdDataB, o.db);
      chk("rdValidA", rdValidA, o.va);
      chk("rdValidB", rdValidB, o.vb);
      chk("writeErr", writeErr, o.err);
      chk("busy", busy, o.bsy);
      chk("flushDone", flushDone, o.done);
    end
  endtask

  task automatic wr(input int idx, input logic [NB-1:0] be, input logic [W-1:0] wd);
    regWrite  = 1'b1;
    decOut    = D'(1) << idx;
    byteEn    = be;
    writeData = wd;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdDataA"}, rdDataA, 0);
    chk({tag, "_rdDataB"}, rdDataB, 0);
    chk({tag, "_rdValidA"}, rdValidA, 0);
    chk({tag, "_rdValidB"}, rdValidB, 0);
    chk({tag, "_writeErr"}, writeErr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_flushDone"}, flushDone, 0);
  endtask

  initial begin
    for (int i = 0; i < D; i++) initialData[i*W +: W] = 32'h1000_0000 + W'(i);
    idle_inputs();
    rdAddrA = '0;
    rdAddrB = '0;
    reset   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;

    // Reset values seen through both read ports.
    rdAddrA = 3; rdAddrB = 7;
    step();

    // Byte-enabled write with same-cycle bypass, then reread.
    wr(2, 4'b0011, 32'hAABB_CCDD);
    rdAddrA = 2; rdAddrB = 2;
    step();
    chk("bypass_value", rdDataA, 32'h1000_CCDD);
    idle_inputs();
    step();

    // Multi-hot and zero selects are rejected.
    regWrite = 1'b1; decOut = 8'b0001_0001; byteEn = 4'hF; writeData = 32'hDEAD_DEAD;
    rdAddrA = 0; rdAddrB = 4;
    step();
    idle_inputs();
    step();
    regWrite = 1'b1; decOut = '0; byteEn = 4'hF; writeData = 32'h1234_5678;
    step();
    idle_inputs();
    // byteEn=0 still marks the entry valid.
    wr(6, 4'b0000, 32'hFFFF_FFFF);
    rdAddrA = 6; rdAddrB = 6;
    step();

    // Fill every entry, then flush with writes and flushReq held during it.
    for (int i = 0; i < D; i++) begin
      wr(i, 4'hF, 32'hFFFF_FFFF);
      rdAddrA = AW'(i); rdAddrB = AW'(D - 1 - i);
      step();
    end
    idle_inputs();
    flushReq = 1'b1;
    step();
    for (int i = 0; i < D; i++) begin
      wr(i, 4'hF, 32'h5A5A_5A5A);
      flushReq = (i != D - 1);
      rdAddrA = AW'(i); rdAddrB = AW'((i + 3) % D);
      step();
    end
    chk("flush_done_seen", flushDone, 1);
    idle_inputs();
    // flushReq in the flushDone cycle starts another flush.
    flushReq = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < D; i++) begin
      rdAddrA = AW'(i); rdAddrB = AW'(D - 1 - i);
      step();
    end
    for (int i = 0; i < D; i++) begin
      rdAddrA = AW'(i); rdAddrB = AW'(i);
      step();
    end

    // Flush request together with a write to entry 5.
    wr(5, 4'hF, 32'hDEAD_BEEF);
    flushReq = 1'b1;
    rdAddrA = 5; rdAddrB = 5;
    step();
    idle_inputs();
    for (int i = 0; i < D + 2; i++) step();
    chk("entry5_restored", rdDataA, 32'h1000_0005);

    // Reset in the middle of a flush.
    for (int i = 3; i < D; i++) begin
      wr(i, 4'hF, 32'h5555_AAAA);
      step();
    end
    idle_inputs();
    flushReq = 1'b1;
    step();
    flushReq = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check_reset_outputs("midflush");
    model_reset();
    @(posedge clk);
    #1;
    chk("midflush_busy_held", busy, 0);
    reset = 1'b1;
    for (int i = 0; i < D; i++) begin
      rdAddrA = AW'(i); rdAddrB = AW'(D - 1 - i);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/register_bank_init.md
Name: register_bank_init

Overview:
Parametrised bank of DEPTH registers, each WIDTH bits wide, replacing single fixed 32-bit registers in the cache datapath (tag/data/status storage).
- Each entry loads a per-entry initial value on reset and keeps a valid bit.
- Writes use one-hot decoded selects with byte enables.
- Two registered read ports with write-first bypass.
- A multi-cycle flush sequencer restores every entry to its initial value.

Parameters:
WIDTH, 32, data bits per entry; must be a multiple of 8
DEPTH, 8, number of entries; must be >= 2
AW, 3, read address width; must equal ceil(log2(DEPTH))
NBYTE, WIDTH/8, number of byte-enable bits

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
regWrite  input  1  write strobe
decOut  input  DEPTH  one-hot entry select for writes
byteEn  input  NBYTE  byte enables; bit k covers writeData[8k+7:8k]
writeData  input  WIDTH  write data
initialData  input  DEPTH*WIDTH  initial value of entry i is initialData[i*WIDTH +: WIDTH]
rdAddrA  input  AW  read address, port A
rdAddrB  input  AW  read address, port B
rdDataA  output  WIDTH  registered read data, port A
rdDataB  output  WIDTH  registered read data, port B
rdValidA  output  1  registered valid bit of the entry read on port A
rdValidB  output  1  registered valid bit of the entry read on port B
writeErr  output  1  one-cycle pulse: write rejected
flushReq  input  1  start a flush
busy  output  1  high while a flush is in progress
flushDone  output  1  one-cycle pulse when a flush completes

Behaviour:
Reset (reset=0, asynchronous):
- entry[i] <= initialData slice i; all valid bits <= 0.
- rdDataA/B <= 0; rdValidA/B <= 0; writeErr, busy, flushDone <= 0.
- FSM <= IDLE; flush counter <= 0.

FSM states: IDLE and FLUSH.

Write (IDLE only):
- Condition: regWrite=1 and decOut has exactly one bit set.
- At the next edge, the bytes of the selected entry with byteEn=1 take writeData; all other bytes hold. The valid bit is set to 1.
- byteEn=0 with a valid select: data unchanged, valid bit still set.

Write rejection:
- regWrite=1 with decOut zero or multi-hot: no state change; writeErr pulses high on the following cycle.
- regWrite=1 in FLUSH: write dropped silently; writeErr stays 0. busy is the master's indication.

Reads:
- 1-cycle latency. The rdData/rdValid registers capture entry[rdAddr] at each edge, every cycle and in every state.
- Address >= DEPTH returns data 0 and valid 0.
- Bypass (write-first): if an accepted write targets the read entry in the same cycle, the read returns the byte-merged new data with valid=1.
- Bypass on flush: if the flush restores the read entry in the same cycle, the read returns the initialData slice with valid=0.
- Both ports may read the same address.

Flush:
- IDLE with flushReq=1 -> FLUSH at the next edge; counter=0, busy=1.
- If a write is presented in that same IDLE cycle, it is performed at that edge; the entry is restored later by the flush.
- Each FLUSH cycle: entry[counter] <= initialData slice; valid[counter] <= 0; counter increments.
- After counter=DEPTH-1 is processed: -> IDLE, busy=0, flushDone=1 for exactly one cycle.
- busy is high for exactly DEPTH cycles.
- flushReq during FLUSH is ignored.
- flushReq in the flushDone cycle (already IDLE) starts a new flush.

Other rules:
- initialData is sampled only at reset and during the flush restore cycles; changes at other times have no effect.
- Reset asserted mid-flush aborts it: all entries initialised at once, FSM to IDLE, no flushDone.

Test Plan:
- Reset with initialData entry i = 32'h1000_0000+i, release; read A=3, B=7 -> next cycle rdDataA=32'h1000_0003, rdDataB=32'h1000_0007, both rdValid=0.
- Write decOut=8'b0000_0100, byteEn=4'b0011, writeData=32'hAABB_CCDD with rdAddrA=2 in the same cycle -> rdDataA=32'h1000_CCDD, rdValidA=1 (bypass); reread next cycle gives the same value.
- Write with decOut=8'b0001_0001 -> writeErr pulses one cycle; entries 0 and 4 unchanged.
- Write entries 0..7 with 32'hFFFF_FFFF, then flushReq -> busy high for 8 cycles, flushDone pulses once; all entries back to initial values, valid=0. Writes attempted during the flush are dropped and writeErr stays 0.
- flushReq together with a write to entry 5 -> write lands, then the flush restores entry 5 to 32'h1000_0005.
- Assert reset at flush cycle 3 -> all outputs 0 immediately; entries at initial values; no flushDone; busy=0.
